instruction_fetch_unit: RTL

//  Instruction fetch front end for the MIPS pipeline. It produces the instruction words, and their opcode fields,

---
 rtl/mips_defs_pkg.sv | 29 ++
 rtl/ifu_fifo.sv | 80 ++++++++
 rtl/instruction_fetch_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/mips_defs_pkg.sv
// Shared MIPS definitions: opcode field values, the NOP word and the fetch-unit FSM encoding.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } ifu_state_e;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Instruction word buffer for the fetch unit: DEPTH x 32, push/pop/flush, head shown as NOP when empty.
module ifu_fifo
    import mips_defs::*;
#(
    parameter int  DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [31:0]   wdata,
    input  logic          pop,
    input  logic          flush,
    output logic [31:0]   rdata,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign count   = count_q;
    assign rdata   = empty ? NOP_WORD : mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage is not reset; count/empty qualify it, and rdata reads as NOP while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch front end: credit-limited in-order imem requests, word FIFO, decode handshake, redirect/flush.
module instruction_fetch_unit
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        Reset_L,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [5:0]  if_opcode,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);

    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

    ifu_state_e    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   deliver_pc_q, deliver_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic          fetch_en_q;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    logic [31:0]   fifo_rdata;
    logic [CW:0]   credits_used;
    logic          req_fire;

    // Only registered terms (plus redirect) reach the request valid; fetch_en_q keeps it low in reset.
    assign credits_used   = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign imem_req_valid = fetch_en_q && (state_q == RUN) && !redirect_valid && (credits_used < CREDITS);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign if_valid    = ~fifo_empty & ~redirect_valid;
    assign fifo_pop    = if_valid & if_ready;
    assign fifo_push   = imem_rsp_valid & (state_q == RUN) & ~redirect_valid;
    assign if_instr    = fifo_rdata;
    assign if_opcode   = fifo_rdata[31:26];
    assign if_pc       = deliver_pc_q;
    assign if_pc_plus4 = pc_inc(deliver_pc_q);

    ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (CLK),
        .rst_n (Reset_L),
        .push  (fifo_push),
        .wdata (imem_rsp_data),
        .pop   (fifo_pop),
        .flush (redirect_valid),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        deliver_pc_d  = deliver_pc_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
        if (redirect_valid) begin
            fetch_pc_d   = redirect_pc & ~32'h3;
            deliver_pc_d = redirect_pc & ~32'h3;
            // Everything still in flight is wrong-path; a response this cycle is already discarded.
            drop_cnt_d   = outstanding_q - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) fetch_pc_d = pc_inc(fetch_pc_q);
            if (fifo_pop) deliver_pc_d = pc_inc(deliver_pc_q);
            if (state_q == FLUSH && imem_rsp_valid) drop_cnt_d = drop_cnt_q - CW'(1);
        end
        state_d = (drop_cnt_d != '0) ? FLUSH : RUN;
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            deliver_pc_q  <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            fetch_en_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            deliver_pc_q  <= deliver_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            fetch_en_q    <= 1'b1;
        end
    end

endmodule
